// File: rtl/cv32e40s_pkg.sv
// ----------------------------------------------------------------------------
// cv32e40s_pkg
// Shared types for the data-side transaction path:
//   gate_state_t    - occupancy of the single-entry request buffer in
//                     cv32e40s_data_trans_gate.
//   obi_data_req_t  - OBI A-channel payload (address phase) from the LSU.
//   obi_data_resp_t - OBI R-channel payload (response phase) toward the LSU.
// ----------------------------------------------------------------------------
package cv32e40s_pkg;

    typedef enum logic {
        GATE_EMPTY = 1'b0,
        GATE_FULL  = 1'b1
    } gate_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [1:0]  memtype;
        logic [2:0]  prot;
        logic        dbg;
    } obi_data_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        exokay;
    } obi_data_resp_t;

endpackage

// File: rtl/cv32e40s_data_trans_watchdog.sv
// ----------------------------------------------------------------------------
// cv32e40s_data_trans_watchdog
// Counts consecutive cycles spent waiting for a data response and pulses
// timeout_o for one cycle when the count reaches TIMEOUT_CYCLES. The count
// then clears so the watchdog re-arms while the wait continues.
// Only instantiated when CV32E40S_DATA_TRANS_GATE_WATCHDOG_EN is defined.
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   active_i  in   a transaction is waiting for its response
//   kick_i    in   a response arrived this cycle (restarts the count)
//   timeout_o out  one-cycle registered timeout pulse
// ----------------------------------------------------------------------------
module cv32e40s_data_trans_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    input  logic kick_i,
    output logic timeout_o
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] count_q;
    logic [15:0] count_d;
    logic        timeout_q;
    logic        timeout_d;

    always_comb begin
        count_d   = count_q;
        timeout_d = 1'b0;
        if (!active_i || kick_i) begin
            count_d = '0;
        end else if (count_q + 16'd1 == LIMIT) begin
            // Limit reached: flag it and start a fresh interval.
            count_d   = '0;
            timeout_d = 1'b1;
        end else begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q && !rst;

endmodule

// File: rtl/cv32e40s_data_trans_gate.sv
// ----------------------------------------------------------------------------
// cv32e40s_data_trans_gate
// Sits between the LSU and the data OBI adapter. Holds one LSU request in a
// stable output register, issues it only while fewer than MAX_OUTSTANDING
// transactions are in flight, and forwards responses unchanged.
// Optional watchdog: define CV32E40S_DATA_TRANS_GATE_WATCHDOG_EN to build in
// the response timeout (TIMEOUT_CYCLES); otherwise timeout_err_o is tied 0.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   lsu_valid_i/lsu_ready_o    LSU request handshake, lsu_trans_i payload
//   trans_valid_o/trans_ready_i request toward OBI adapter, trans_o payload
//   resp_valid_i/resp_i        response from OBI adapter
//   lsu_resp_valid_o/lsu_resp_o response toward LSU (combinational)
//   outstanding_o              granted transactions awaiting a response
//   idle_o                     buffer empty and nothing outstanding
//   protocol_err_o             pulse: response arrived with nothing outstanding
//   timeout_err_o              pulse: watchdog expired
// ----------------------------------------------------------------------------
module cv32e40s_data_trans_gate
    import cv32e40s_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   lsu_valid_i,
    output logic                                   lsu_ready_o,
    input  obi_data_req_t                          lsu_trans_i,
    output logic                                   trans_valid_o,
    input  logic                                   trans_ready_i,
    output obi_data_req_t                          trans_o,
    input  logic                                   resp_valid_i,
    input  obi_data_resp_t                         resp_i,
    output logic                                   lsu_resp_valid_o,
    output obi_data_resp_t                         lsu_resp_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   idle_o,
    output logic                                   protocol_err_o,
    output logic                                   timeout_err_o
);

    localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    // Elaboration-time guard on the supported parameter ranges.
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 7) begin : g_bad_max_outstanding
        $error("MAX_OUTSTANDING must be in 1..7");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    gate_state_t      state_q;
    gate_state_t      state_d;
    obi_data_req_t    buf_q;
    obi_data_req_t    buf_d;
    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] outstanding_d;
    logic             protocol_err_q;
    logic             protocol_err_d;

    logic issue_ok;
    logic issue;
    logic accept;
    logic dec;

    // Outstanding count only rises on an issue, so once trans_valid_o is
    // high it cannot drop before the grant: the A-channel stays stable.
    assign issue_ok      = (outstanding_q < MAX_CNT);
    assign trans_valid_o = !rst && (state_q == GATE_FULL) && issue_ok;
    assign issue         = trans_valid_o && trans_ready_i;
    assign lsu_ready_o   = !rst && ((state_q == GATE_EMPTY) || issue);
    assign accept        = lsu_valid_i && lsu_ready_o;
    // A response with nothing outstanding must not underflow the count.
    assign dec           = resp_valid_i && (outstanding_q != '0);

    always_comb begin
        state_d        = state_q;
        buf_d          = buf_q;
        outstanding_d  = outstanding_q;
        protocol_err_d = resp_valid_i && (outstanding_q == '0) && !rst;

        if (accept) begin
            state_d = GATE_FULL;
            buf_d   = lsu_trans_i;
        end else if (issue) begin
            state_d = GATE_EMPTY;
        end

        case ({issue, dec})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= GATE_EMPTY;
            buf_q          <= '0;
            outstanding_q  <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            buf_q          <= buf_d;
            outstanding_q  <= outstanding_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign trans_o          = buf_q;
    assign lsu_resp_valid_o = resp_valid_i;
    assign lsu_resp_o       = resp_i;
    assign outstanding_o    = rst ? '0 : outstanding_q;
    assign idle_o           = rst || ((state_q == GATE_EMPTY) && (outstanding_q == '0));
    assign protocol_err_o   = protocol_err_q && !rst;

`ifdef CV32E40S_DATA_TRANS_GATE_WATCHDOG_EN
    // The grant cycle itself counts as the first cycle of waiting, so the
    // pulse lands TIMEOUT_CYCLES cycles after the grant.
    logic wd_active;
    assign wd_active = (outstanding_q != '0) || issue;

    cv32e40s_data_trans_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .active_i  (wd_active),
        .kick_i    (resp_valid_i),
        .timeout_o (timeout_err_o)
    );
`else
    assign timeout_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40s_data_trans_gate.sv
// ----------------------------------------------------------------------------
// tb_cv32e40s_data_trans_gate
// Directed scenarios plus a randomized run checked against a queue-based
// model (one pending request slot, FIFO of in-flight requests).
// ----------------------------------------------------------------------------
module tb_cv32e40s_data_trans_gate;
    import cv32e40s_pkg::*;

    localparam int MAX_OUT = 2;
    localparam int TMO     = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           lsu_valid = 1'b0;
    logic           lsu_ready;
    obi_data_req_t  lsu_trans = '0;
    logic           trans_valid;
    logic           trans_ready = 1'b0;
    obi_data_req_t  trans;
    logic           resp_valid = 1'b0;
    obi_data_resp_t resp = '0;
    logic           lsu_resp_valid;
    obi_data_resp_t lsu_resp;
    logic [1:0]     outstanding;
    logic           idle;
    logic           perr;
    logic           terr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cv32e40s_data_trans_gate #(
        .MAX_OUTSTANDING (MAX_OUT),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .lsu_valid_i      (lsu_valid),
        .lsu_ready_o      (lsu_ready),
        .lsu_trans_i      (lsu_trans),
        .trans_valid_o    (trans_valid),
        .trans_ready_i    (trans_ready),
        .trans_o          (trans),
        .resp_valid_i     (resp_valid),
        .resp_i           (resp),
        .lsu_resp_valid_o (lsu_resp_valid),
        .lsu_resp_o       (lsu_resp),
        .outstanding_o    (outstanding),
        .idle_o           (idle),
        .protocol_err_o   (perr),
        .timeout_err_o    (terr)
    );

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        lsu_valid   = 1'b0;
        trans_ready = 1'b0;
        resp_valid  = 1'b0;
    endtask

    function automatic obi_data_req_t rand_req();
        obi_data_req_t r;
        r.addr    = $urandom;
        r.we      = 1'($urandom);
        r.be      = 4'($urandom);
        r.wdata   = $urandom;
        r.memtype = 2'($urandom);
        r.prot    = 3'($urandom);
        r.dbg     = 1'($urandom);
        return r;
    endfunction

    function automatic obi_data_resp_t rand_resp();
        obi_data_resp_t r;
        r.rdata  = $urandom;
        r.err    = 1'($urandom);
        r.exokay = 1'($urandom);
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; lsu_valid = 1'b1; trans_ready = 1'b1; resp_valid = 1'b1;
        lsu_trans = rand_req();
        for (int c = 0; c < 2; c++) begin
            step();
            n_checks++; if (lsu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", lsu_ready); end
            n_checks++; if (trans_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b expected 0", trans_valid); end
            n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", idle); end
            n_checks++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
            n_checks++; if (perr !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b expected 0", perr); end
            n_checks++; if (terr !== 1'b0) begin n_fail++; $display("FAIL reset_terr: got %b expected 0", terr); end
        end
        step();
        rst = 1'b0;
        clear_inputs();
        #1;
        n_checks++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b expected 1", lsu_ready); end
        n_checks++; if (perr !== 1'b0) begin n_fail++; $display("FAIL post_reset_perr: got %b expected 0", perr); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle: got %b expected 1", idle); end
        $display("txn reset released");
    endtask

    task automatic test_single_store();
        obi_data_req_t  p = rand_req();
        obi_data_resp_t r = rand_resp();
        int exp_out [5] = '{0, 0, 1, 1, 0};
        int exp_tv  [5] = '{0, 1, 0, 0, 0};
        p.we = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            lsu_valid = (c == 0); lsu_trans = p;
            trans_ready = (c == 1);
            resp_valid = (c == 3); resp = r;
            #1;
            n_checks++; if (outstanding !== 2'(exp_out[c])) begin n_fail++; $display("FAIL single_outstanding c%0d: got %0d expected %0d", c, outstanding, exp_out[c]); end
            n_checks++; if (trans_valid !== 1'(exp_tv[c])) begin n_fail++; $display("FAIL single_tvalid c%0d: got %b expected %0d", c, trans_valid, exp_tv[c]); end
            if (c == 1) begin
                n_checks++; if (trans !== p) begin n_fail++; $display("FAIL single_trans: got %h expected %h", trans, p); end
            end
            if (c == 3) begin
                n_checks++; if (lsu_resp_valid !== 1'b1 || lsu_resp !== r) begin n_fail++; $display("FAIL single_resp: got %b/%h expected 1/%h", lsu_resp_valid, lsu_resp, r); end
            end
            if (c == 4) begin
                n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL single_idle: got %b expected 1", idle); end
            end
        end
        $display("txn single store addr=%h", p.addr);
        clear_inputs();
    endtask

    task automatic test_limit();
        obi_data_req_t p [3];
        int exp_tv  [10] = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 0};
        int exp_out [10] = '{0, 0, 1, 2, 2, 1, 2, 1, 0, 0};
        int exp_rdy [5]  = '{1, 1, 1, 0, 0};
        int exp_idx [6]  = '{0, 0, 1, 2, 2, 2};
        for (int i = 0; i < 3; i++) begin
            p[i] = rand_req();
            p[i].we = 1'b0;
        end
        for (int c = 0; c < 10; c++) begin
            step();
            lsu_valid = (c < 3);
            lsu_trans = p[(c < 3) ? c : 2];
            trans_ready = 1'b1;
            resp_valid = (c == 4) || (c == 6) || (c == 7);
            resp = rand_resp();
            #1;
            n_checks++; if (trans_valid !== 1'(exp_tv[c])) begin n_fail++; $display("FAIL limit_tvalid c%0d: got %b expected %0d", c, trans_valid, exp_tv[c]); end
            n_checks++; if (outstanding !== 2'(exp_out[c])) begin n_fail++; $display("FAIL limit_outstanding c%0d: got %0d expected %0d", c, outstanding, exp_out[c]); end
            if (c < 5) begin
                n_checks++; if (lsu_ready !== 1'(exp_rdy[c])) begin n_fail++; $display("FAIL limit_ready c%0d: got %b expected %0d", c, lsu_ready, exp_rdy[c]); end
            end
            if (c >= 1 && c <= 5) begin
                n_checks++; if (trans !== p[exp_idx[c]]) begin n_fail++; $display("FAIL limit_trans c%0d: got %h expected %h", c, trans, p[exp_idx[c]]); end
            end
            if (c >= 8) begin
                n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL limit_idle c%0d: got %b expected 1", c, idle); end
            end
        end
        $display("txn limit: three loads, third held until first response");
        clear_inputs();
    endtask

    task automatic test_grant_stall();
        obi_data_req_t p0 = rand_req();
        obi_data_req_t p1 = rand_req();
        for (int c = 0; c < 11; c++) begin
            step();
            lsu_valid = (c <= 6);
            lsu_trans = (c == 0) ? p0 : p1;
            trans_ready = (c == 6) || (c == 7);
            resp_valid = (c == 8) || (c == 9);
            #1;
            if (c >= 1 && c <= 6) begin
                n_checks++; if (trans_valid !== 1'b1 || trans !== p0) begin n_fail++; $display("FAIL stall_hold c%0d: got %b/%h expected 1/%h", c, trans_valid, trans, p0); end
                n_checks++; if (lsu_ready !== (c == 6)) begin n_fail++; $display("FAIL stall_ready c%0d: got %b expected %b", c, lsu_ready, (c == 6)); end
            end
            if (c == 7) begin
                n_checks++; if (trans_valid !== 1'b1 || trans !== p1 || outstanding !== 2'd1) begin n_fail++; $display("FAIL stall_next: got %b/%h/%0d expected 1/%h/1", trans_valid, trans, outstanding, p1); end
            end
            if (c == 8) begin
                n_checks++; if (outstanding !== 2'd2) begin n_fail++; $display("FAIL stall_outstanding: got %0d expected 2", outstanding); end
            end
            if (c == 10) begin
                n_checks++; if (idle !== 1'b1 || outstanding !== 2'd0) begin n_fail++; $display("FAIL stall_drain: got idle %b cnt %0d expected 1/0", idle, outstanding); end
            end
        end
        $display("txn grant stall addr=%h then addr=%h", p0.addr, p1.addr);
        clear_inputs();
    endtask

    task automatic test_spurious();
        obi_data_resp_t r = rand_resp();
        for (int c = 0; c < 3; c++) begin
            step();
            resp_valid = (c == 0); resp = r;
            #1;
            n_checks++; if (perr !== (c == 1)) begin n_fail++; $display("FAIL spur_perr c%0d: got %b expected %b", c, perr, (c == 1)); end
            n_checks++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL spur_outstanding c%0d: got %0d expected 0", c, outstanding); end
            if (c == 0) begin
                n_checks++; if (lsu_resp_valid !== 1'b1 || lsu_resp !== r) begin n_fail++; $display("FAIL spur_forward: got %b/%h expected 1/%h", lsu_resp_valid, lsu_resp, r); end
            end
        end
        $display("txn spurious response rdata=%h", r.rdata);
        clear_inputs();
    endtask

    task automatic test_reset_midflight();
        for (int c = 0; c < 7; c++) begin
            step();
            lsu_valid = (c <= 2); lsu_trans = rand_req();
            trans_ready = (c == 1) || (c == 2) || (c == 4);
            rst = (c == 3);
            resp_valid = (c == 4);
            #1;
            if (c == 3) begin
                n_checks++; if (lsu_ready !== 1'b0 || trans_valid !== 1'b0 || idle !== 1'b1 || outstanding !== 2'd0 || perr !== 1'b0) begin
                    n_fail++; $display("FAIL midreset_during: rdy %b tv %b idle %b cnt %0d perr %b expected 0 0 1 0 0", lsu_ready, trans_valid, idle, outstanding, perr);
                end
            end
            if (c == 4) begin
                n_checks++; if (trans_valid !== 1'b0 || lsu_ready !== 1'b1 || outstanding !== 2'd0 || idle !== 1'b1) begin
                    n_fail++; $display("FAIL midreset_after: tv %b rdy %b cnt %0d idle %b expected 0 1 0 1", trans_valid, lsu_ready, outstanding, idle);
                end
            end
            if (c >= 4) begin
                n_checks++; if (perr !== (c == 5)) begin n_fail++; $display("FAIL midreset_perr c%0d: got %b expected %b", c, perr, (c == 5)); end
            end
        end
        $display("txn reset mid-flight, late response flagged");
        clear_inputs();
    endtask

    task automatic test_watchdog();
        obi_data_req_t p = rand_req();
        bit exp_t;
        for (int c = 0; c < 16; c++) begin
            step();
            lsu_valid = (c == 0); lsu_trans = p;
            trans_ready = (c == 1);
            resp_valid = (c == 14);
            #1;
`ifdef CV32E40S_DATA_TRANS_GATE_WATCHDOG_EN
            exp_t = (c == 1 + TMO);
`else
            exp_t = 1'b0;
`endif
            n_checks++; if (terr !== exp_t) begin n_fail++; $display("FAIL watchdog c%0d: got %b expected %b", c, terr, exp_t); end
        end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL watchdog_idle: got %b expected 1", idle); end
        $display("txn watchdog probe addr=%h", p.addr);
        clear_inputs();
    endtask

    task automatic test_random();
        obi_data_req_t pending [$];
        obi_data_req_t inflight [$];
        bit exp_perr = 1'b0;
        bit exp_tv, exp_ready, exp_idle;
        int old_n;
        for (int c = 0; c < 400; c++) begin
            step();
            lsu_valid   = ($urandom_range(0, 9) < 6);
            lsu_trans   = rand_req();
            trans_ready = ($urandom_range(0, 9) < 6);
            resp_valid  = (inflight.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            resp        = rand_resp();
            exp_tv    = (pending.size() == 1) && (inflight.size() < MAX_OUT);
            exp_ready = (pending.size() == 0) || (exp_tv && trans_ready);
            exp_idle  = (pending.size() == 0) && (inflight.size() == 0);
            #1;
            n_checks++; if (trans_valid !== exp_tv) begin n_fail++; $display("FAIL rand_tvalid c%0d: got %b expected %b", c, trans_valid, exp_tv); end
            n_checks++; if (lsu_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready c%0d: got %b expected %b", c, lsu_ready, exp_ready); end
            n_checks++; if (outstanding !== 2'(inflight.size())) begin n_fail++; $display("FAIL rand_outstanding c%0d: got %0d expected %0d", c, outstanding, inflight.size()); end
            n_checks++; if (idle !== exp_idle) begin n_fail++; $display("FAIL rand_idle c%0d: got %b expected %b", c, idle, exp_idle); end
            n_checks++; if (perr !== exp_perr) begin n_fail++; $display("FAIL rand_perr c%0d: got %b expected %b", c, perr, exp_perr); end
            n_checks++; if (lsu_resp_valid !== resp_valid || lsu_resp !== resp) begin n_fail++; $display("FAIL rand_resp c%0d: got %b/%h expected %b/%h", c, lsu_resp_valid, lsu_resp, resp_valid, resp); end
            if (pending.size() == 1) begin
                n_checks++; if (trans !== pending[0]) begin n_fail++; $display("FAIL rand_trans c%0d: got %h expected %h", c, trans, pending[0]); end
            end
`ifndef CV32E40S_DATA_TRANS_GATE_WATCHDOG_EN
            n_checks++; if (terr !== 1'b0) begin n_fail++; $display("FAIL rand_terr c%0d: got %b expected 0", c, terr); end
`endif
            old_n = inflight.size();
            if (resp_valid && old_n > 0) void'(inflight.pop_front());
            if (exp_tv && trans_ready) begin
                $display("txn issue c%0d addr=%h we=%b", c, pending[0].addr, pending[0].we);
                inflight.push_back(pending.pop_front());
            end
            if (lsu_valid && exp_ready) pending.push_back(lsu_trans);
            exp_perr = resp_valid && (old_n == 0);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_limit();
        test_grant_stall();
        test_spurious();
        test_reset_midflight();
        test_watchdog();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
